bpu_pcgen: RTL and testbench
============================

Name: bpu_pcgen

Overview:
- Parametrised fetch-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Successor to the current static predict-not-taken PC+4 update logic; sits ahead of CodeROM/IFID in the IF stage.
- Owns the architectural fetch PC register, predicts the next PC each cycle, and is trained by resolved branches/jumps from EX.
- Accepts EX redirects on misprediction, and pipeline stalls.

Parameters:
- DATA_WIDTH, 64, PC/target width.
- ENTRIES, 16, BTB entries; power of two, >=2; IDX_BITS = log2(ENTRIES).
- TAG_BITS, 10, stored tag width; IDX_BITS+2+TAG_BITS <= DATA_WIDTH.
- RESET_PC, 64'h8000_0000, fetch PC after reset.
- CTR_INIT, 2'b01, counter value at reset and on flush.
- CNT_WIDTH, 32, mispredict counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold fetch PC (load-use stall from ID/EX)
- redirect_i  in  1  EX misprediction; load redirect_pc_i
- redirect_pc_i  in  DATA_WIDTH  corrected next PC
- upd_valid_i  in  1  resolved control-flow instruction in EX
- upd_pc_i  in  DATA_WIDTH  PC of the resolved instruction
- upd_taken_i  in  1  actual direction
- upd_target_i  in  DATA_WIDTH  actual taken target
- flush_bpu_i  in  1  invalidate all BTB entries (fence.i)
- pc_o  out  DATA_WIDTH  current fetch PC (registered)
- pred_taken_o  out  1  BTB hit and counter[1] for pc_o
- pred_npc_o  out  DATA_WIDTH  predicted next PC for pc_o, carried down the pipe for the EX compare
- mispredict_cnt_o  out  CNT_WIDTH  number of accepted redirects

Behaviour:
- Reset (async assert, sync release):
  - pc_o=RESET_PC; all valid=0; all ctr=CTR_INIT; targets/tags=0; mispredict_cnt_o=0.
  - Combinational outputs follow: pred_taken_o=0, pred_npc_o=RESET_PC+4.
- Lookup (combinational on pc_q):
  - idx = pc_q[IDX_BITS+1:2].
  - tag = pc_q[IDX_BITS+2+TAG_BITS-1 : IDX_BITS+2].
  - hit = valid[idx] && tag_q[idx]==tag.
  - pred_taken_o = hit && ctr[idx][1].
  - pred_npc_o = pred_taken_o ? target[idx] : pc_q+4; addition wraps modulo 2^DATA_WIDTH.
- PC update, per clock, in priority order:
  - redirect_i: pc_q <= redirect_pc_i. Wins over stall_i.
  - else stall_i: pc_q holds.
  - else: pc_q <= pred_npc_o.
- Mispredict counter: increments on every cycle with redirect_i=1; wraps at 2^CNT_WIDTH.
- Training (registered; takes effect the cycle after upd_valid_i):
  - Update index and tag are derived from upd_pc_i with the same bit slices as lookup.
  - Tag hit, taken: ctr saturating increment (11 stays 11); target <= upd_target_i.
  - Tag hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate/replace the entry: valid=1, tag, target=upd_target_i, ctr=2'b10.
  - Miss, not taken: no change.
- Training is independent of stall_i and redirect_i; it is applied even during stall and redirect.
- Same-cycle update and lookup on one index: lookup sees the old state (no bypass).
- flush_bpu_i: all valid <= 0 and all ctr <= CTR_INIT next cycle.
  - Has priority over a same-cycle update; that update is dropped.
  - Does not affect pc_q.
- Misaligned PCs: bits [1:0] are ignored for indexing; pc_q is not realigned.
- Reset mid-operation: immediate return to reset values; any in-flight update is lost.

Decomposition:
- pipeline_pkg additions:
  - BTB_Entry_t struct: valid, tag, target, ctr.
  - BPU_Update_t struct: valid, pc, taken, target.
  - Counter constants: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
- One sub-module: bpu_table.
  - Storage array with async reset.
  - Combinational read port; one write port with flush.
  - Holds the saturating-counter update function.
- bpu_pcgen holds pc_q, next-PC priority mux and mispredict counter.

Test Plan:
- Reset release, no stall: pc_o = 0x8000_0000, then 0x8000_0004, then 0x8000_0008; pred_taken_o=0 throughout.
- stall_i=1 for 3 cycles with pc_o=0x8000_0008: pc_o holds 0x8000_0008. After release: 0x8000_000C.
- Allocation:
  - Stimulus: upd pc=0x8000_0010, taken, target=0x8000_0100.
  - When pc_o reaches 0x8000_0010: pred_taken_o=1, pred_npc_o=0x8000_0100, next pc_o=0x8000_0100.
- Counter saturation on the same entry:
  - 2 not-taken updates: ctr 10->01->00, pred_taken_o=0 at 0x8000_0010.
  - 4 taken updates: ctr reaches 11 and stays.
  - 1 not-taken update: ctr 10, still predicts taken.
- Aliasing: 0x8000_0050 has idx 4 (same as 0x8000_0010) and tag 1 (vs tag 0).
  - Fetch at 0x8000_0050: pred_taken_o=0.
  - Taken update at 0x8000_0050, target 0x8000_0200: entry replaced; 0x8000_0010 now misses.
- Simultaneous events:
  - redirect_i=1 with stall_i=1, redirect_pc_i=0x8000_0040: pc_o=0x8000_0040 next cycle; mispredict_cnt_o goes 0->1.
  - flush_bpu_i together with a taken update: all lookups miss afterwards.

Source files
------------

// File: rtl/bpu_pcgen_pkg.sv
// Shared definitions for the fetch-PC generator: 2-bit direction counter
// encoding and the saturating counter helpers.
package bpu_pcgen_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/bpu_pcgen_table.sv
// Direct-mapped BTB with 2-bit direction counters: one combinational read
// port for fetch lookup and one registered training port with bulk flush.
module bpu_table
  import bpu_pcgen_pkg::*;
#(
  parameter int   DATA_WIDTH = 64,
  parameter int   ENTRIES    = 16,
  parameter int   TAG_BITS   = 10,
  parameter ctr_t CTR_INIT   = 2'b01,
  localparam int  IDX_BITS   = $clog2(ENTRIES),
  localparam int  KEY_W      = IDX_BITS + TAG_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [KEY_W-1:0]      rd_key_i,
  output logic                  rd_taken_o,
  output logic [DATA_WIDTH-1:0] rd_target_o,
  input  logic                  upd_valid_i,
  input  logic [KEY_W-1:0]      upd_key_i,
  input  logic                  upd_taken_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i,
  input  logic                  flush_i
);

  typedef struct packed {
    logic                  valid;
    logic [TAG_BITS-1:0]   tag;
    logic [DATA_WIDTH-1:0] target;
    ctr_t                  ctr;
  } btb_entry_t;

  btb_entry_t tbl_q [ENTRIES];
  btb_entry_t tbl_d [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx, upd_idx;
  logic [TAG_BITS-1:0] rd_tag, upd_tag;
  logic                rd_hit, upd_hit;

  assign rd_idx  = rd_key_i[IDX_BITS-1:0];
  assign rd_tag  = rd_key_i[KEY_W-1:IDX_BITS];
  assign upd_idx = upd_key_i[IDX_BITS-1:0];
  assign upd_tag = upd_key_i[KEY_W-1:IDX_BITS];

  assign rd_hit      = tbl_q[rd_idx].valid && (tbl_q[rd_idx].tag == rd_tag);
  assign rd_taken_o  = rd_hit && tbl_q[rd_idx].ctr[1];
  assign rd_target_o = tbl_q[rd_idx].target;

  assign upd_hit = tbl_q[upd_idx].valid && (tbl_q[upd_idx].tag == upd_tag);

  always_comb begin
    tbl_d = tbl_q;
    if (flush_i) begin
      // Flush wins over a same-cycle update; tags/targets are left stale.
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_d[i].valid = 1'b0;
        tbl_d[i].ctr   = CTR_INIT;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          tbl_d[upd_idx].ctr    = ctr_inc(tbl_q[upd_idx].ctr);
          tbl_d[upd_idx].target = upd_target_i;
        end else begin
          tbl_d[upd_idx].ctr    = ctr_dec(tbl_q[upd_idx].ctr);
        end
      end else if (upd_taken_i) begin
        tbl_d[upd_idx].valid  = 1'b1;
        tbl_d[upd_idx].tag    = upd_tag;
        tbl_d[upd_idx].target = upd_target_i;
        tbl_d[upd_idx].ctr    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid  <= 1'b0;
        tbl_q[i].tag    <= '0;
        tbl_q[i].target <= '0;
        tbl_q[i].ctr    <= CTR_INIT;
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

endmodule

// File: rtl/bpu_pcgen.sv
// Fetch-PC generator: owns the fetch PC, predicts the next PC from the BTB,
// and applies EX redirects and stalls.
module bpu_pcgen
  import bpu_pcgen_pkg::*;
#(
  parameter int                  DATA_WIDTH = 64,
  parameter int                  ENTRIES    = 16,
  parameter int                  TAG_BITS   = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 64'h8000_0000,
  parameter ctr_t                CTR_INIT   = 2'b01,
  parameter int                  CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  upd_valid_i,
  input  logic [DATA_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i,
  input  logic                  flush_bpu_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  pred_taken_o,
  output logic [DATA_WIDTH-1:0] pred_npc_o,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int KEY_W    = IDX_BITS + TAG_BITS;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] btb_target;
  logic                  btb_taken;
  logic                  unused_upd_pc;

  // Only the index/tag slice of upd_pc_i matters; the rest is ignored.
  assign unused_upd_pc = ^upd_pc_i;

  bpu_table #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (ENTRIES),
    .TAG_BITS   (TAG_BITS),
    .CTR_INIT   (CTR_INIT)
  ) u_table (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_key_i     (pc_q[KEY_W+1:2]),
    .rd_taken_o   (btb_taken),
    .rd_target_o  (btb_target),
    .upd_valid_i  (upd_valid_i),
    .upd_key_i    (upd_pc_i[KEY_W+1:2]),
    .upd_taken_i  (upd_taken_i),
    .upd_target_i (upd_target_i),
    .flush_i      (flush_bpu_i)
  );

  assign pred_taken_o     = btb_taken;
  assign pred_npc_o       = btb_taken ? btb_target : pc_q + DATA_WIDTH'(4);
  assign pc_o             = pc_q;
  assign mispredict_cnt_o = cnt_q;

  always_comb begin
    pc_d  = pred_npc_o;
    cnt_d = cnt_q;
    if (redirect_i) begin
      pc_d  = redirect_pc_i;
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (stall_i) begin
      pc_d  = pc_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bpu_pcgen.sv
// Directed bench for bpu_pcgen: sequential fetch, stall, BTB allocate/train,
// aliasing, redirect-vs-stall priority, flush and asynchronous reset.
module tb_bpu_pcgen;

  logic        clk;
  logic        rst_n;
  logic        stall, redirect, upd_valid, upd_taken, flush;
  logic [63:0] redirect_pc, upd_pc, upd_target;
  logic [63:0] pc, pred_npc;
  logic        pred_taken;
  logic [31:0] mcnt;

  int checks = 0;
  int errors = 0;

  bpu_pcgen dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .stall_i          (stall),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_taken_i      (upd_taken),
    .upd_target_i     (upd_target),
    .flush_bpu_i      (flush),
    .pc_o             (pc),
    .pred_taken_o     (pred_taken),
    .pred_npc_o       (pred_npc),
    .mispredict_cnt_o (mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [63:0] p, input logic t, input logic [63:0] tg);
    upd_valid  = v;
    upd_pc     = p;
    upd_taken  = t;
    upd_target = tg;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; flush = 1'b0;
    redirect_pc = '0;
    set_upd(1'b0, '0, 1'b0, '0);
    #12;
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_taken", {63'd0, pred_taken}, 64'd0);
    chk("rst_npc", pred_npc, 64'h8000_0004);
    chk("rst_cnt", {32'd0, mcnt}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential fetch
    chk("seq0", pc, 64'h8000_0000);
    step(); chk("seq1", pc, 64'h8000_0004);
    step(); chk("seq2", pc, 64'h8000_0008);
    chk("seq_taken", {63'd0, pred_taken}, 64'd0);

    // Stall holds the PC
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_hold", pc, 64'h8000_0008);
    end
    stall = 1'b0;
    step(); chk("stall_rel", pc, 64'h8000_000C);

    // Allocate entry for 0x10 while fetching 0x0C
    set_upd(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100);
    step();
    set_upd(1'b0, '0, 1'b0, '0);
    chk("alloc_pc", pc, 64'h8000_0010);
    chk("alloc_taken", {63'd0, pred_taken}, 64'd1);
    chk("alloc_npc", pred_npc, 64'h8000_0100);
    stall = 1'b1;

    // Counter training while stalled at 0x10 (ctr 10)
    set_upd(1'b1, 64'h8000_0010, 1'b0, 64'h0);
    step(); chk("nt1_taken", {63'd0, pred_taken}, 64'd0);   // 01
    chk("nt1_npc", pred_npc, 64'h8000_0014);
    step(); chk("nt2_taken", {63'd0, pred_taken}, 64'd0);   // 00
    set_upd(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100);
    step(); chk("t1_taken", {63'd0, pred_taken}, 64'd0);    // 01
    step(); chk("t2_taken", {63'd0, pred_taken}, 64'd1);    // 10
    step(); chk("t3_taken", {63'd0, pred_taken}, 64'd1);    // 11
    step(); chk("t4_taken", {63'd0, pred_taken}, 64'd1);    // 11 saturated
    set_upd(1'b1, 64'h8000_0010, 1'b0, 64'h0);
    step(); chk("sat_nt1", {63'd0, pred_taken}, 64'd1);     // 10
    step(); chk("sat_nt2", {63'd0, pred_taken}, 64'd0);     // 01
    set_upd(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0180);
    step();                                                 // 10, new target
    set_upd(1'b0, '0, 1'b0, '0);
    chk("retgt_taken", {63'd0, pred_taken}, 64'd1);
    chk("retgt_npc", pred_npc, 64'h8000_0180);
    chk("stall_pc", pc, 64'h8000_0010);
    stall = 1'b0;
    step(); chk("follow_tgt", pc, 64'h8000_0180);

    // Redirect wins over stall and bumps the counter
    chk("cnt0", {32'd0, mcnt}, 64'd0);
    redirect = 1'b1; stall = 1'b1; redirect_pc = 64'h8000_0040;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("redir_pc", pc, 64'h8000_0040);
    chk("cnt1", {32'd0, mcnt}, 64'd1);
    step(); step(); step(); step();
    chk("walk_pc", pc, 64'h8000_0050);
    chk("alias_miss", {63'd0, pred_taken}, 64'd0);
    chk("alias_npc", pred_npc, 64'h8000_0054);

    // Replace idx 4 with tag 1
    stall = 1'b1;
    set_upd(1'b1, 64'h8000_0050, 1'b1, 64'h8000_0200);
    step();
    set_upd(1'b0, '0, 1'b0, '0);
    chk("repl_taken", {63'd0, pred_taken}, 64'd1);
    chk("repl_npc", pred_npc, 64'h8000_0200);
    redirect = 1'b1; redirect_pc = 64'h8000_0010;
    step();
    redirect = 1'b0;
    chk("old_pc", pc, 64'h8000_0010);
    chk("old_miss", {63'd0, pred_taken}, 64'd0);
    chk("cnt2", {32'd0, mcnt}, 64'd2);

    // Flush with a same-cycle taken update: update dropped, all miss
    redirect = 1'b1; redirect_pc = 64'h8000_0050;
    flush = 1'b1;
    set_upd(1'b1, 64'h8000_0020, 1'b1, 64'h8000_0300);
    step();
    redirect = 1'b0; flush = 1'b0;
    set_upd(1'b0, '0, 1'b0, '0);
    chk("flush_pc", pc, 64'h8000_0050);
    chk("flush_miss50", {63'd0, pred_taken}, 64'd0);
    redirect = 1'b1; redirect_pc = 64'h8000_0020;
    step();
    redirect = 1'b0;
    chk("flush_miss20", {63'd0, pred_taken}, 64'd0);
    chk("flush_npc20", pred_npc, 64'h8000_0024);
    chk("cnt4", {32'd0, mcnt}, 64'd4);
    stall = 1'b0;

    // Asynchronous reset mid-operation
    step();
    chk("pre_rst_pc", pc, 64'h8000_0024);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 64'h8000_0000);
    chk("async_rst_cnt", {32'd0, mcnt}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("post_rst_pc", pc, 64'h8000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
